// File: rtl/fpu_result_buffer.sv
// Result buffer behind the FP32 arithmetic unit: a first-word-fall-through FIFO of
// {result, status, tag} that also keeps sticky IEEE flags and a wrapping result counter.
module fpu_result_buffer #(
   parameter int DATA_W   = 32,
   parameter int STATUS_W = 5,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [STATUS_W-1:0]      in_status,
   input  logic                     in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [STATUS_W-1:0]      out_status,
   output logic                     out_tag,
   output logic [$clog2(DEPTH):0]   count,
   output logic [STATUS_W-1:0]      sticky_status,
   input  logic                     clear_sticky,
   output logic [CNT_W-1:0]         result_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_PARTIAL,
      S_FULL
   } occ_state_t;

   occ_state_t            state_q, state_d;
   logic [OCC_W-1:0]      count_q;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [DATA_W-1:0]     mem_data   [DEPTH];
   logic [STATUS_W-1:0]   mem_status [DEPTH];
   logic                  mem_tag    [DEPTH];
   logic [STATUS_W-1:0]   sticky_q;
   logic [CNT_W-1:0]      result_cnt_q;
   logic                  push, pop;

   // Handshake flags come from the registered occupancy state only, so out_ready
   // never reaches in_ready combinationally.
   assign in_ready  = (state_q != S_FULL);
   assign out_valid = (state_q != S_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_data      = mem_data[rd_ptr];
   assign out_status    = mem_status[rd_ptr];
   assign out_tag       = mem_tag[rd_ptr];
   assign count         = count_q;
   assign sticky_status = sticky_q;
   assign result_cnt    = result_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_EMPTY: begin
            if (push) state_d = S_PARTIAL;
         end
         S_PARTIAL: begin
            if (push && !pop && count_q == OCC_W'(DEPTH - 1)) state_d = S_FULL;
            else if (pop && !push && count_q == OCC_W'(1))    state_d = S_EMPTY;
         end
         S_FULL: begin
            if (pop) state_d = S_PARTIAL;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + OCC_W'(1);
            2'b01:   count_q <= count_q - OCC_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array is reset on purpose, so the head reads as zero after reset
   // and a reset mid-operation leaves no stale result visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i]   <= '0;
            mem_status[i] <= '0;
            mem_tag[i]    <= 1'b0;
         end
      end else if (push) begin
         mem_data[wr_ptr]   <= in_data;
         mem_status[wr_ptr] <= in_status;
         mem_tag[wr_ptr]    <= in_tag;
      end
   end

   // A clear coinciding with a push keeps the incoming flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q     <= '0;
         result_cnt_q <= '0;
      end else begin
         if (clear_sticky) sticky_q <= push ? in_status : '0;
         else if (push)    sticky_q <= sticky_q | in_status;
         if (push) result_cnt_q <= result_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

Result-side stage placed directly downstream of the FP32 arithmetic unit (fpnew_top in the FPM build). It accepts `result_o`/`status_o`/`tag_o` through the unit's `out_valid_o`/`out_ready_i` handshake and holds them in a small first-word-fall-through FIFO. It releases them to the checker/consumer through a second valid/ready handshake. It also keeps sticky IEEE exception flags and a running result counter for the scoreboard.

## Interface
- `DATA_W`, 32, result width (FP32).
- `STATUS_W`, 5, exception flags {NV, DZ, OF, UF, NX}, MSB first.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16, width of accepted-result counter.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  producer result valid (from `out_valid_o`).
- `in_ready`  out  1  buffer can accept (to `out_ready_i`).
- `in_data`  in  DATA_W  result value.
- `in_status`  in  STATUS_W  exception flags for this result.
- `in_tag`  in  1  tag travelling with the operation.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  DATA_W  head result.
- `out_status`  out  STATUS_W  head flags.
- `out_tag`  out  1  head tag.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `sticky_status`  out  STATUS_W  OR of flags of all accepted results since reset/clear.
- `clear_sticky`  in  1  synchronous clear of `sticky_status`.
- `result_cnt`  out  CNT_W  number of accepted results, wraps.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes {data, status, tag} at `wr_ptr`, and `wr_ptr` increments.
- Pop: `out_valid && out_ready` at a rising edge increments `rd_ptr`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH (entry DEPTH-1 → 0).
- `count` next value: +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_ready = (count != DEPTH)`. It is driven from registered state only; there is no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- `out_data`/`out_status`/`out_tag` are read combinationally from entry `rd_ptr` (first-word fall-through).
- Occupancy states EMPTY (count=0), PARTIAL, FULL (count=DEPTH):
  - EMPTY→PARTIAL on push (DEPTH≥2).
  - PARTIAL→FULL on push-only reaching DEPTH.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop-only reaching 0.
  - Push and pop in the same cycle in PARTIAL: no state change.
- EMPTY with `in_valid` and `out_ready`: push only. The new entry is not bypassed to the output in the same cycle.
- FULL with `in_valid` and `out_ready`: pop only. `in_ready` is 0, so the producer holds its result.
- Sticky flags:
  - On push: `sticky_status |= in_status`.
  - `clear_sticky` without push: `sticky_status <= 0`.
  - `clear_sticky` together with push: `sticky_status <= in_status`. The new flags are not lost.
- `result_cnt` increments on every push and wraps 2^CNT_W−1 → 0.
- Entry data is not modified by a pop; only pointers move.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `count`=0, `wr_ptr`=`rd_ptr`=0.
  - All entries = 0, so `out_data`=0, `out_status`=0, `out_tag`=0.
  - `out_valid`=0, `in_ready`=1.
  - `sticky_status`=0, `result_cnt`=0.
- Reset mid-operation discards all stored entries. There is no drain.
- Latency: a result pushed at edge k appears on `out_*` with `out_valid`=1 in the cycle after edge k, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained when PARTIAL.
- `in_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from FULL.
- `out_*` must remain stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset then single push of `in_data`=0x3F800000, `in_status`=0, `in_tag`=1 → next cycle `out_valid`=1, `out_data`=0x3F800000, `out_tag`=1, `count`=1, `result_cnt`=1. Then pop → `count`=0, `out_valid`=0.
- With `out_ready`=0, push 0x1, 0x2, 0x3, 0x4, then hold `in_valid` with 0x5:
  - After the 4th push: `in_ready`=0, `count`=4.
  - 0x5 is not accepted.
  - Raise `out_ready` for one cycle → 0x1 popped; 0x5 accepted the following cycle.
  - Drain order must be 0x2, 0x3, 0x4, 0x5.
- Wrap-around: 10 results 0xA0..0xA9 with simultaneous push/pop every cycle after the first push → outputs 0xA0..0xA9 in order, `count` stays 1, pointers wrap twice.
- Sticky flags:
  - Push status 5'b00001, then 5'b10000 → `sticky_status`=5'b10001.
  - `clear_sticky` alone → 0.
  - `clear_sticky` with push of 5'b00100 → 5'b00100.
- Reset mid-operation: fill 3 entries, assert `rst` asynchronously between edges → `count`, `out_valid`, `out_data`, `sticky_status`, `result_cnt` all 0 immediately and `in_ready`=1. The first push after release is output first.
- Counter wrap (with `CNT_W`=4): push 17 results → `result_cnt`=1.
